// File: rtl/input_debouncer.sv
// Purpose: synchronise raw switch/button inputs, reject contact bounce, publish level + rise/fall strobes.
// Latency: a raw change captured at edge E0 appears on level/rise/fall at edge E1+STABLE_CYCLES.
// Backpressure: none; strobes are single-cycle pulses for an edge-driven consumer.
module input_debouncer #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 1_000_000,
    parameter logic [WIDTH-1:0] INIT_LEVEL    = '0,
    parameter int               CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Terminal count: a level must be seen differing on this many consecutive edges.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]             sync1_q, sync1_d;
    logic [WIDTH-1:0]             sync2_q, sync2_d;
    logic [WIDTH-1:0]             level_q, level_d;
    logic [WIDTH-1:0]             rise_q,  rise_d;
    logic [WIDTH-1:0]             fall_q,  fall_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q,   cnt_d;

    // Next-state: synchroniser shift, per-channel stable/pending counting, strobe generation.
    // A channel is "stable" when its synchronised input matches level and "pending" otherwise;
    // any return to the old level during pending throws away the accumulated count.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        if (!rst_n) begin
            // Reset wins over everything, including a count in progress.
            sync1_d = INIT_LEVEL;
            sync2_d = INIT_LEVEL;
            level_d = INIT_LEVEL;
            cnt_d   = '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // State registers; reset is applied through the _d path so it is synchronous.
    always_ff @(posedge clk) begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cnt_q   <= cnt_d;
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Input conditioning stage between the board's raw switches/push-buttons and the LED controller. It does three things per input:
- synchronises each asynchronous raw input into the `clk` domain;
- rejects contact bounce by requiring a level to be stable for a programmable number of cycles;
- publishes a clean level plus single-cycle rise and fall strobes.

The LED controller consumes `level` for the switch bits and `rise` of the button bit as its invert toggle, replacing its internal free-running cooldown.

## Interface
Parameters:
- `WIDTH`, default 4: number of independent channels (3 switches + 1 button).
- `STABLE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a new level (20 ms at 50 MHz). Must be ≥ 2.
- `INIT_LEVEL`, default {WIDTH{1'b0}}: per-bit value loaded into the synchroniser and `level` on reset (set a bit to 1 for active-low buttons).
- `CNT_W`, default $clog2(STABLE_CYCLES): width of each channel counter.

Ports:
- `clk`, in, 1: system clock. Everything is in this single domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `raw_in`, in, WIDTH: raw asynchronous switch/button inputs.
- `level`, out, WIDTH: debounced, registered level per channel.
- `rise`, out, WIDTH: one-cycle strobe on each accepted 0→1 transition of `level`.
- `fall`, out, WIDTH: one-cycle strobe on each accepted 1→0 transition of `level`.

## Operation
Each channel is independent and identical. Per channel i:
- **Synchroniser:** two flops, `s1 <= raw_in[i]` and `s2 <= s1`. Only `s2` is used downstream.
- **Counter:** `cnt`, CNT_W bits, unsigned. It never exceeds STABLE_CYCLES-1, so it cannot wrap.
- **States:**
  - STABLE: `s2 == level`.
  - PENDING: `s2 != level`.
- **At every clk edge:**
  - If `rst_n == 0`: `s1`, `s2` and `level` load INIT_LEVEL[i]; `cnt` = 0; `rise` = `fall` = 0. This takes priority over every other action, including mid-count.
  - Else if `s2 == level` (STABLE): `cnt` <= 0; `rise` = `fall` = 0. A bounce back to the old level discards all progress.
  - Else if `cnt == STABLE_CYCLES-1`: `level` <= `s2`; `cnt` <= 0; `rise` <= `s2`; `fall` <= ~`s2`.
  - Else: `cnt` <= `cnt` + 1; `rise` = `fall` = 0.
- **Strobes:** `rise`/`fall` are registered. They are high for exactly the one cycle in which the new `level` first appears, and are never both high on the same bit.
- **Simultaneous events:** independent channels may change in the same cycle, and their strobes assert together.
- **No spurious output after reset:** `raw_in` equal to INIT_LEVEL during and after reset produces no strobe.

## Timing
- **Reset values:**
  - `level` = INIT_LEVEL;
  - `rise` = 0;
  - `fall` = 0;
  - all counters = 0;
  - synchroniser = INIT_LEVEL.
- **Latency:** a raw change sampled into `s1` at edge E0 reaches `s2` at E1. `level`, `rise` and `fall` update at edge E1+STABLE_CYCLES, i.e. STABLE_CYCLES+1 edges after capture.
- **Minimum pulse:** a raw pulse shorter than STABLE_CYCLES cycles, as seen at `s2`, is filtered completely.
- **Minimum spacing:** at most one accepted transition per STABLE_CYCLES cycles per channel.
- **Throughput:** `rise` feeds an edge-driven consumer directly; no handshake and no back-pressure.

## Test plan
All scenarios use STABLE_CYCLES=4, WIDTH=4, INIT_LEVEL=4'b1000.

1. **Reset state:**
   - Stimulus: hold `rst_n`=0 for 3 cycles with `raw_in`=4'b1000, then release.
   - Required response: `level`=4'b1000, and `rise`/`fall` stay 0 for 20 cycles.
2. **Clean rise:**
   - Stimulus: set `raw_in[0]`=1 before edge E0.
   - Required response: `level[0]`=1 and `rise[0]`=1 after edge E5; `rise[0]`=0 after E6.
3. **Bounce rejection:**
   - Stimulus: toggle `raw_in[1]` 1,0,1,0 every 2 cycles, then hold it at 1.
   - Required response: no strobe during the bounce; exactly one `rise[1]`, at 5 edges after the final stable capture.
4. **Active-low button fall:**
   - Stimulus: drive `raw_in[3]` 1→0 for 10 cycles.
   - Required response: a single `fall[3]` pulse, and `level[3]`=0.
5. **Simultaneous channels:**
   - Stimulus: `raw_in` changes 4'b1000→4'b0111 in one cycle.
   - Required response: at the same edge, `rise`=4'b0111, `fall`=4'b1000, and `level`=4'b0111.
6. **Reset mid-count:**
   - Stimulus: pulse `rst_n`=0 for 1 cycle 2 cycles after a `raw_in[2]` change, then hold `raw_in[2]`.
   - Required response: `level[2]` returns to 0; `rise[2]` asserts 5 edges after the post-reset capture, never earlier.
